// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// ALUControl codes, data-processing cmd codes, condition codes and Op classes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_LSL = 3'b100;
  localparam logic [2:0] ALU_LSR = 3'b101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flag register with FlagW gating, plus the combinational condition
// check against the registered flags.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       flag_en,
  output logic       CondEx
);

  logic [3:0] flags;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  // NZ and CV halves are written independently; a failed condition blocks both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (flag_en && CondEx) begin
      if (FlagW[1]) flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder and datapath selects.
// Define CTRL_SHIFT_EN to decode MOV (cmd 1101, I=0) into LSL/LSR via Sh.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [1:0] Sh,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl
);

  state_t     state, state_nxt;
  logic       funct_i, funct_s;
  logic [3:0] cmd;
  logic [2:0] dec_alu;
  logic       no_write;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       flag_en;

  assign funct_i = Funct[5];
  assign cmd     = Funct[4:1];
  assign funct_s = Funct[0];

`ifndef CTRL_SHIFT_EN
  logic unused_sh;
  assign unused_sh = ^Sh;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_nxt = funct_i ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  state_nxt = S_MEMADR;
          OP_BR:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = S_MEMWB;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Unknown commands fall back to ADD with writeback suppressed.
  always_comb begin
    dec_alu  = ALU_ADD;
    no_write = 1'b0;
    flag_w   = {funct_s, 1'b0};
    case (cmd)
      CMD_ADD: flag_w[0] = funct_s;
      CMD_SUB: begin
        dec_alu   = ALU_SUB;
        flag_w[0] = funct_s;
      end
      CMD_AND: dec_alu = ALU_AND;
      CMD_ORR: dec_alu = ALU_ORR;
      CMD_CMP: begin
        dec_alu   = ALU_SUB;
        no_write  = 1'b1;
        flag_w[0] = funct_s;
      end
`ifdef CTRL_SHIFT_EN
      CMD_MOV: begin
        if (!funct_i && Sh == SH_LSL)      dec_alu = ALU_LSL;
        else if (!funct_i && Sh == SH_LSR) dec_alu = ALU_LSR;
        else                               no_write = 1'b1;
      end
`endif
      default: no_write = 1'b1;
    endcase
  end

  assign flag_en = (state == S_EXECUTER) || (state == S_EXECUTEI);

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (flag_w),
    .flag_en  (flag_en),
    .CondEx   (cond_ex)
  );

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = Op;
    RegSrc     = {Op == OP_MEM, Op == OP_BR};
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      S_EXECUTER: ALUControl = dec_alu;
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dec_alu;
      end
      S_ALUWB: RegWrite = cond_ex & ~no_write;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    // Reset holds state in FETCH, whose enables must not reach the datapath.
    if (!reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output patterns of each
// instruction class, flag update/condition behaviour and mid-instruction reset.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [1:0] Sh;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;

  int vec_cnt = 0;
  int err_cnt = 0;

  // {PCWrite,MemWrite,RegWrite,IRWrite, AdrSrc,ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
  localparam logic [12:0] P_FETCH  = 13'b1001_01_10_10_000;
  localparam logic [12:0] P_DECODE = 13'b0000_01_10_10_000;
  localparam logic [12:0] P_RSTF   = 13'b0000_01_10_10_000;
  localparam logic [12:0] P_MEMADR = 13'b0000_00_01_00_000;
  localparam logic [12:0] P_MEMRD  = 13'b0000_10_00_00_000;
  localparam logic [12:0] P_MEMWB  = 13'b0010_00_00_01_000;
  localparam logic [12:0] P_MEMWR  = 13'b0100_10_00_00_000;
  localparam logic [12:0] P_EXADD  = 13'b0000_00_00_00_000;
  localparam logic [12:0] P_EXSUB  = 13'b0000_00_00_00_001;
  localparam logic [12:0] P_EXLSL  = 13'b0000_00_00_00_100;
  localparam logic [12:0] P_EXLSR  = 13'b0000_00_00_00_101;
  localparam logic [12:0] P_EXIADD = 13'b0000_00_01_00_000;
  localparam logic [12:0] P_WB1    = 13'b0010_00_00_00_000;
  localparam logic [12:0] P_WB0    = 13'b0000_00_00_00_000;
  localparam logic [12:0] P_BR1    = 13'b1000_00_01_10_000;
  localparam logic [12:0] P_BR0    = 13'b0000_00_01_10_000;

  logic [12:0] obs;
  assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl};

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Sh         (Sh),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle; ALUFlags carry the real value
  // only in the third (EXECUTE) cycle so mistimed sampling shows up.
  task automatic instr(input string tag, input logic [3:0] cnd, input logic [1:0] op,
                       input logic [5:0] fn, input logic [1:0] sh, input logic [3:0] aluf,
                       input int n, input logic [12:0] e0, input logic [12:0] e1,
                       input logic [12:0] e2, input logic [12:0] e3, input logic [12:0] e4);
    logic [12:0] exp_p;
    Cond  = cnd;
    Op    = op;
    Funct = fn;
    Sh    = sh;
    for (int i = 0; i < n; i++) begin
      ALUFlags = (i == 2) ? aluf : ~aluf;
      #1;
      case (i)
        0:       exp_p = e0;
        1:       exp_p = e1;
        2:       exp_p = e2;
        3:       exp_p = e3;
        default: exp_p = e4;
      endcase
      check_vec($sformatf("%s[%0d]", tag, i), {3'b000, obs}, {3'b000, exp_p});
      if (i == 0)
        check_vec($sformatf("%s_sel", tag), {12'h000, ImmSrc, RegSrc},
                  {12'h000, op, op == 2'b01, op == 2'b10});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    Cond     = 4'b1110;
    Op       = 2'b00;
    Funct    = 6'b0;
    Sh       = 2'b00;
    ALUFlags = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_out", {3'b000, obs}, {3'b000, P_RSTF});
    check_vec("rst_flags", {12'h000, dut.u_cond.flags}, 16'h0000);
    reset = 1'b1;

    instr("add", 4'b1110, 2'b00, 6'b0_0100_0, 2'b00, 4'b1111, 4,
          P_FETCH, P_DECODE, P_EXADD, P_WB1, 13'b0);
    check_vec("add_flags", {12'h000, dut.u_cond.flags}, 16'h0000);
    instr("cmp", 4'b1110, 2'b00, 6'b0_1010_1, 2'b00, 4'b0100, 4,
          P_FETCH, P_DECODE, P_EXSUB, P_WB0, 13'b0);
    check_vec("cmp_flags", {12'h000, dut.u_cond.flags}, 16'h0004);
    instr("b_eq", 4'b0000, 2'b10, 6'b0, 2'b00, 4'b0000, 3,
          P_FETCH, P_DECODE, P_BR1, 13'b0, 13'b0);
    instr("b_ne", 4'b0001, 2'b10, 6'b0, 2'b00, 4'b0000, 3,
          P_FETCH, P_DECODE, P_BR0, 13'b0, 13'b0);
    instr("ldr", 4'b1110, 2'b01, 6'b011001, 2'b00, 4'b0000, 5,
          P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB);
    instr("str", 4'b1110, 2'b01, 6'b011000, 2'b00, 4'b0000, 4,
          P_FETCH, P_DECODE, P_MEMADR, P_MEMWR, 13'b0);
`ifdef CTRL_SHIFT_EN
    instr("mov_lsr", 4'b1110, 2'b00, 6'b0_1101_0, 2'b01, 4'b0000, 4,
          P_FETCH, P_DECODE, P_EXLSR, P_WB1, 13'b0);
    instr("mov_lsl", 4'b1110, 2'b00, 6'b0_1101_0, 2'b00, 4'b0000, 4,
          P_FETCH, P_DECODE, P_EXLSL, P_WB1, 13'b0);
`else
    instr("mov_lsr", 4'b1110, 2'b00, 6'b0_1101_0, 2'b01, 4'b0000, 4,
          P_FETCH, P_DECODE, P_EXADD, P_WB0, 13'b0);
    instr("mov_lsl", 4'b1110, 2'b00, 6'b0_1101_0, 2'b00, 4'b0000, 4,
          P_FETCH, P_DECODE, P_EXADD, P_WB0, 13'b0);
`endif
    check_vec("mov_flags", {12'h000, dut.u_cond.flags}, 16'h0004);

    instr("cmp0", 4'b1110, 2'b00, 6'b0_1010_1, 2'b00, 4'b0000, 4,
          P_FETCH, P_DECODE, P_EXSUB, P_WB0, 13'b0);
    check_vec("cmp0_flags", {12'h000, dut.u_cond.flags}, 16'h0000);
    instr("adds_eq", 4'b0000, 2'b00, 6'b0_0100_1, 2'b00, 4'b1111, 4,
          P_FETCH, P_DECODE, P_EXADD, P_WB0, 13'b0);
    check_vec("adds_eq_flags", {12'h000, dut.u_cond.flags}, 16'h0000);
    instr("b_eq2", 4'b0000, 2'b10, 6'b0, 2'b00, 4'b0000, 3,
          P_FETCH, P_DECODE, P_BR0, 13'b0, 13'b0);

    instr("addis", 4'b1110, 2'b00, 6'b1_0100_1, 2'b00, 4'b1111, 4,
          P_FETCH, P_DECODE, P_EXIADD, P_WB1, 13'b0);
    check_vec("addis_flags", {12'h000, dut.u_cond.flags}, 16'h000f);
    instr("b_hi", 4'b1000, 2'b10, 6'b0, 2'b00, 4'b0000, 3,
          P_FETCH, P_DECODE, P_BR0, 13'b0, 13'b0);
    instr("b_ge", 4'b1010, 2'b10, 6'b0, 2'b00, 4'b0000, 3,
          P_FETCH, P_DECODE, P_BR1, 13'b0, 13'b0);
    instr("b_nv", 4'b1111, 2'b10, 6'b0, 2'b00, 4'b0000, 3,
          P_FETCH, P_DECODE, P_BR0, 13'b0, 13'b0);
    instr("nop", 4'b1110, 2'b11, 6'b0, 2'b00, 4'b0000, 2,
          P_FETCH, P_DECODE, 13'b0, 13'b0, 13'b0);

    // Abandon a load in MEMRD with the flags still set to 1111.
    instr("ldr_abort", 4'b1110, 2'b01, 6'b011001, 2'b00, 4'b0000, 3,
          P_FETCH, P_DECODE, P_MEMADR, 13'b0, 13'b0);
    check_vec("memrd", {3'b000, obs}, {3'b000, P_MEMRD});
    #1 reset = 1'b0;
    #1;
    check_vec("arst_out", {3'b000, obs}, {3'b000, P_RSTF});
    check_vec("arst_flags", {12'h000, dut.u_cond.flags}, 16'h0000);
    @(posedge clk);
    #1;
    check_vec("arst_hold", {3'b000, obs}, {3'b000, P_RSTF});
    reset = 1'b1;
    instr("restart", 4'b1110, 2'b11, 6'b0, 2'b00, 4'b0000, 2,
          P_FETCH, P_DECODE, 13'b0, 13'b0, 13'b0);
    #1;
    check_vec("restart_fetch", {3'b000, obs}, {3'b000, P_FETCH});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM-subset processor, directly upstream of the ALU.
- Holds the main state machine, decodes the instruction fields and drives every datapath enable and mux select.
- Produces the 3-bit `ALUControl` the ALU consumes, and registers the ALU's `ALUFlags` into the NZCV flags.
- Gates all architectural writes through the condition check.

## Interface
Parameters: none; encodings come from the shared package.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `Cond`  in  4  instruction [31:28]
- `Op`  in  2  instruction [27:26]
- `Funct`  in  6  instruction [25:20]: I, cmd[3:0], S
- `Sh`  in  2  instruction [6:5], shift type
- `ALUFlags`  in  4  NZCV from the ALU, same cycle
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite`  out  1 each  write enables
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ALUSrcA`  out  1  ALU operand A select: 0 = register, 1 = PC
- `ALUSrcB`  out  2  ALU operand B select: 00 = register, 01 = immediate, 10 = constant 4
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU direct
- `ImmSrc`  out  2  immediate format select
- `RegSrc`  out  2  register-file address selects
- `ALUControl`  out  3  ALU operation code

## Operation
**States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.

**Transitions:**
- FETCH → DECODE.
- DECODE, by `Op`:
  - 00 with I = 0 → EXECUTER
  - 00 with I = 1 → EXECUTEI
  - 01 → MEMADR
  - 10 → BRANCH
  - 11 → FETCH (treated as NOP)
- MEMADR → MEMRD if `Funct[0]` (load), else MEMWR.
- MEMRD → MEMWB → FETCH. MEMWR → FETCH.
- EXECUTER / EXECUTEI → ALUWB → FETCH.
- BRANCH → FETCH.

**Outputs per state** (everything not listed is 0; `ALUControl` is ADD unless stated):
- FETCH: `IRWrite`=1, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10, `PCWrite`=1.
- DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
- MEMADR: `ALUSrcB`=01.
- MEMRD: `AdrSrc`=1.
- MEMWB: `ResultSrc`=01, `RegWrite`=CondEx.
- MEMWR: `AdrSrc`=1, `MemWrite`=CondEx.
- EXECUTER: `ALUSrcB`=00, `ALUControl` decoded.
- EXECUTEI: `ALUSrcB`=01, `ALUControl` decoded.
- ALUWB: `RegWrite`=CondEx & ~NoWrite.
- BRANCH: `ALUSrcB`=01, `ResultSrc`=10, `PCWrite`=CondEx.
- `ImmSrc`=`Op` and `RegSrc`={Op==01, Op==10}, combinational in every state.

**ALU decode** (`cmd` → `ALUControl`):
- 0100 ADD → 000; 0010 SUB → 001; 0000 AND → 010; 1100 ORR → 011.
- 1010 CMP → 001, with NoWrite=1.
- 1101 MOV: see Configuration.
- Any other cmd → 000 with NoWrite=1.

**Flags:**
- FlagW[1] (NZ) = S.
- FlagW[0] (CV) = S & cmd ∈ {ADD, SUB, CMP}.
- Flags are written at the end of EXECUTER/EXECUTEI, only when CondEx is true.

**Condition check:** CondEx is computed combinationally from `Cond` and the registered flags.
- EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per the ARM definition.
- AL (1110) = 1; 1111 = 0.

## Timing
- Cycles per instruction: data processing (including CMP) 4, LDR 5, STR 4, B 3, Op = 11 2.
- Outputs are combinational from state, registered flags and instruction fields.
- `ALUFlags` are sampled at the rising edge that leaves EXECUTE; a following instruction sees the new flags at its DECODE.
- While `reset` = 0: state = FETCH, flags = 0000, and `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite` are forced to 0. The first rising edge after release performs FETCH.
- Reset asserted mid-instruction: the partial instruction is abandoned and the flags are cleared immediately (asynchronous).
- A flag-setting instruction whose condition fails leaves the flags unchanged.

## Configuration
Macro `CTRL_SHIFT_EN`.
- **Defined:** MOV (cmd 1101, I = 0) decodes `Sh`: 00 → LSL (100), 01 → LSR (101). Other `Sh` values → 000 with NoWrite=1. FlagW[0]=0 for shifts.
- **Undefined:** cmd 1101 takes the "other cmd" path; `ALUControl` never produces 100 or 101.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum
  - `ALUControl` localparams: ADD, SUB, AND, ORR, LSL, LSR
  - cmd codes and condition codes
- Sub-module `cond_unit` holds the NZCV flag register, FlagW gating and the CondEx evaluation.
- The FSM and decoder live in the top module.

## Test plan
- Reset low then release, cmd=0100, I=0, `Cond`=1110: states FETCH, DECODE, EXECUTER, ALUWB; `ALUControl`=000 in EXECUTER; `RegWrite`=1 in ALUWB only.
- CMP (cmd 1010, S=1), `ALUFlags`=0100 → flags = 0100. Then B with `Cond`=0000 (EQ) → `PCWrite`=1 in BRANCH. With `Cond`=0001 (NE) → `PCWrite`=0.
- LDR (`Op`=01, `Funct[0]`=1) → 5 states with `ResultSrc`=01 in MEMWB. STR → `MemWrite`=1 in MEMWR only, 4 cycles.
- With `CTRL_SHIFT_EN`: MOV, `Sh`=01 → `ALUControl`=101; `Sh`=00 → 100. Without the macro → 000 and `RegWrite`=0 in ALUWB.
- Assert reset during MEMRD → enables drop to 0 at once, flags read 0000, and the FSM restarts in FETCH.
- ADDS with `Cond`=0000 while Z=0 → flags unchanged and `RegWrite`=0 in ALUWB.
